// File: rtl/key_expander.sv
// AES-128/192/256 key schedule expander: two cycles per generated word.
// Optional KEY_ZEROIZE_EN adds a zeroize input that wipes the stored schedule.

module aes_sbox_reg (
  input  logic       mclk,
  input  logic       en,
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] out_d;
  logic [7:0] out_q;

  always_comb begin
    out_d = out_q;
    if (en) out_d = SBOX[in];
  end

  always_ff @(posedge mclk) begin
    out_q <= out_d;
  end

  assign out = out_q;

endmodule

module key_expander #(
  parameter int NW_MAX = 60
) (
  input  logic         mclk,
  input  logic         arst_n,
`ifdef KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [255:0] cipherkey,
  input  logic         start_key,
  input  logic         keylength128,
  input  logic         keylength192,
  input  logic         keylength256,
  input  logic [3:0]   round_count,
  output logic [127:0] roundkey,
  output logic         key_ready,
  output logic         busy_key
);

  typedef enum logic [1:0] {IDLE, LOAD, SUB, GEN} state_e;
  typedef enum logic [1:0] {KL128, KL192, KL256} klen_e;

  state_e      state_q, state_d;
  klen_e       klen_q, klen_d, klen_sel;
  logic [5:0]  i_q, i_d;
  logic [2:0]  mod_q, mod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        key_ready_q, key_ready_d;
  logic        busy_key_q, busy_key_d;
  logic [31:0] w_q [NW_MAX];
  logic [31:0] w_d [NW_MAX];

  logic [5:0]  nk;
  logic [3:0]  nr;
  logic [5:0]  nw_last;
  logic [31:0] w_prev;
  logic [31:0] w_old;
  logic [31:0] temp;
  logic        sbox_en;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [7:0]  rcon_x2;
  logic [5:0]  rk_base;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox_reg u_sbox (
      .mclk (mclk),
      .en   (sbox_en),
      .in   (sbox_in[8*b +: 8]),
      .out  (sbox_out[8*b +: 8])
    );
  end

  // 128 wins over 192 wins over 256; nothing selected means 128
  always_comb begin
    klen_sel = KL128;
    priority case (1'b1)
      keylength128: klen_sel = KL128;
      keylength192: klen_sel = KL192;
      keylength256: klen_sel = KL256;
      default:      klen_sel = KL128;
    endcase
  end

  always_comb begin
    nk      = 6'd4;
    nr      = 4'd10;
    nw_last = 6'd43;
    unique case (klen_q)
      KL192: begin
        nk      = 6'd6;
        nr      = 4'd12;
        nw_last = 6'd51;
      end
      KL256: begin
        nk      = 6'd8;
        nr      = 4'd14;
        nw_last = 6'd59;
      end
      default: begin
        nk      = 6'd4;
        nr      = 4'd10;
        nw_last = 6'd43;
      end
    endcase
  end

  assign w_prev  = w_q[i_q - 6'd1];
  assign w_old   = w_q[i_q - nk];
  assign rcon_x2 = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    i_d         = i_q;
    mod_d       = mod_q;
    rcon_d      = rcon_q;
    key_ready_d = key_ready_q;
    busy_key_d  = busy_key_q;
    w_d         = w_q;
    sbox_en     = 1'b0;
    sbox_in     = w_prev;
    temp        = w_prev;
    unique case (state_q)
      IDLE: begin
        if (start_key) begin
          state_d     = LOAD;
          klen_d      = klen_sel;
          key_ready_d = 1'b0;
          busy_key_d  = 1'b1;
        end
      end
      LOAD: begin
        for (int j = 0; j < 8; j++) begin
          if (6'(j) < nk) w_d[j] = cipherkey[255-32*j -: 32];
        end
        i_d     = nk;
        mod_d   = '0;
        rcon_d  = 8'h01;
        state_d = SUB;
      end
      SUB: begin
        sbox_en = 1'b1;
        if (mod_q == 3'd0) sbox_in = {w_prev[23:0], w_prev[31:24]};
        state_d = GEN;
      end
      GEN: begin
        if (mod_q == 3'd0) begin
          temp   = sbox_out ^ {rcon_q, 24'h0};
          rcon_d = rcon_x2;
        end else if (nk == 6'd8 && mod_q == 3'd4) begin
          temp = sbox_out;
        end
        w_d[i_q] = w_old ^ temp;
        if (i_q == nw_last) begin
          state_d     = IDLE;
          key_ready_d = 1'b1;
          busy_key_d  = 1'b0;
        end else begin
          i_d     = i_q + 6'd1;
          mod_d   = (mod_q == 3'(nk - 6'd1)) ? 3'd0 : mod_q + 3'd1;
          state_d = SUB;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef KEY_ZEROIZE_EN
    if (zeroize) begin
      state_d     = IDLE;
      i_d         = '0;
      mod_d       = '0;
      rcon_d      = 8'h01;
      key_ready_d = 1'b0;
      busy_key_d  = 1'b0;
      w_d         = '{default: '0};
    end
`endif
  end

  always_ff @(posedge mclk) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      klen_q      <= KL128;
      i_q         <= '0;
      mod_q       <= '0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b0;
      busy_key_q  <= 1'b0;
      w_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      i_q         <= i_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      key_ready_q <= key_ready_d;
      busy_key_q  <= busy_key_d;
      w_q         <= w_d;
    end
  end

  // rounds past Nr are masked, which also hides stale words of a longer key
  always_comb begin
    roundkey = '0;
    rk_base  = {round_count, 2'b00};
    if (key_ready_q && (round_count <= nr)) begin
      roundkey = {w_q[rk_base],         w_q[rk_base + 6'd1],
                  w_q[rk_base + 6'd2],  w_q[rk_base + 6'd3]};
    end
  end

  assign key_ready = key_ready_q;
  assign busy_key  = busy_key_q;

endmodule
